// File: rtl/prime_key_seq_pkg.sv
// Shared types and constants for the prime key sequencer.
// The SIEVE state only exists when PRIME_KEY_SIEVE_EN is defined.
package key_gen_pkg;

  localparam int RND_W    = 16;
  localparam int TRIES_W  = 16;
  localparam int SIEVE_M0 = 3;
  localparam int SIEVE_M1 = 5;
  localparam int SIEVE_M2 = 17;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_TEST  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_EMIT  = 3'd4,
    ST_DONE  = 3'd5
`ifdef PRIME_KEY_SIEVE_EN
    ,
    ST_SIEVE = 3'd6
`endif
  } state_t;

endpackage

// File: rtl/prime_key_seq_sieve.sv
// cand_sieve: word-serial small-prime screen for a candidate.
// Since 2^16 = 1 (mod 3, 5, 17), the candidate residue equals the residue of
// the sum of its 16-bit words. One word is added per cycle after start; done
// pulses for one cycle with composite qualified by it.
// Built only when PRIME_KEY_SIEVE_EN is defined.
`ifdef PRIME_KEY_SIEVE_EN
module cand_sieve
  import key_gen_pkg::*;
#(
  parameter int WORDSIZE = 272
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [WORDSIZE-1:0] cand,
  output logic                done,
  output logic                composite
);

  localparam int NWORDS = WORDSIZE / RND_W;
  localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

  logic [IDX_W-1:0] idx;
  logic             running;
  logic [31:0]      sum;

  // Accumulate one word per cycle, flag done after the last word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx     <= '0;
      running <= 1'b0;
      sum     <= '0;
      done    <= 1'b0;
    end else if (start) begin
      idx     <= '0;
      running <= 1'b1;
      sum     <= '0;
      done    <= 1'b0;
    end else if (running) begin
      sum <= sum + {16'd0, cand[int'(idx)*RND_W +: RND_W]};
      if (idx == LAST_IDX) begin
        running <= 1'b0;
        done    <= 1'b1;
      end else begin
        idx <= idx + 1'b1;
      end
    end else begin
      done <= 1'b0;
    end
  end

  assign composite = ((sum % 32'(SIEVE_M0)) == 32'd0) ||
                     ((sum % 32'(SIEVE_M1)) == 32'd0) ||
                     ((sum % 32'(SIEVE_M2)) == 32'd0);

endmodule
`endif

// File: rtl/prime_key_seq.sv
// prime_key_seq: generates NUM_KEYS odd, top-bit-set primes of WORDSIZE bits
// from a 16-bit random word stream, using a shared external primality tester.
// Composite results step the candidate by +2 up to MAX_STEPS tests, then a
// fresh candidate is drawn. Keys leave over a valid/ready handshake.
// Optional: define PRIME_KEY_SIEVE_EN to screen candidates by 3/5/17 first.
//
// state | meaning
// IDLE  | waiting for start
// FILL  | loading random words into cand, LSW first
// SIEVE | (optional) small-prime screen of cand
// TEST  | one-cycle test_start pulse to the tester
// WAIT  | waiting for test_done
// EMIT  | key offered to the consumer
// DONE  | all keys delivered, finish held
module prime_key_seq
  import key_gen_pkg::*;
#(
  parameter int WORDSIZE  = 272,
  parameter int NUM_KEYS  = 3,
  parameter int MAX_STEPS = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [RND_W-1:0]    rnd_word,
  input  logic                rnd_valid,
  output logic                rnd_ready,
  output logic [WORDSIZE-1:0] cand,
  output logic                test_start,
  input  logic                test_done,
  input  logic                test_prime,
  output logic [WORDSIZE-1:0] key_out,
  output logic [7:0]          key_idx,
  output logic [TRIES_W-1:0]  tries,
  output logic                key_valid,
  input  logic                key_ready,
  output logic                busy,
  output logic                finish
);

  localparam int NWORDS = WORDSIZE / RND_W;
  localparam int WCNT_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int STEP_W = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1;

  localparam logic [WCNT_W-1:0]   LAST_WORD = WCNT_W'(NWORDS - 1);
  localparam logic [STEP_W-1:0]   LAST_STEP = STEP_W'(MAX_STEPS - 1);
  localparam logic [7:0]          LAST_KEY  = 8'(NUM_KEYS - 1);
  localparam logic [WORDSIZE-1:0] MSB_ONE   = {1'b1, {(WORDSIZE-1){1'b0}}};
  localparam logic [WORDSIZE-1:0] LSB_ONE   = WORDSIZE'(1);

  state_t                state;
  logic [WCNT_W-1:0]     word_cnt;
  logic [STEP_W-1:0]     step_cnt;
  logic [7:0]            key_cnt;
  logic [WORDSIZE-1:0]   cand_fill;
  logic [WORDSIZE-1:0]   cand_step;

`ifdef PRIME_KEY_SIEVE_EN
  logic sieve_start;
  logic sieve_done;
  logic sieve_composite;

  cand_sieve #(
    .WORDSIZE (WORDSIZE)
  ) u_sieve (
    .clk       (clk),
    .reset     (reset),
    .start     (sieve_start),
    .cand      (cand),
    .done      (sieve_done),
    .composite (sieve_composite)
  );
`endif

  // Next candidate values: current word merged in, or +2 with the top bit re-forced.
  always_comb begin
    cand_fill = cand;
    cand_fill[int'(word_cnt)*RND_W +: RND_W] = rnd_word;
    cand_step = (cand + WORDSIZE'(2)) | MSB_ONE;
  end

  // Sequencer FSM with registered handshake/status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      cand       <= '0;
      word_cnt   <= '0;
      step_cnt   <= '0;
      key_cnt    <= '0;
      tries      <= '0;
      rnd_ready  <= 1'b0;
      test_start <= 1'b0;
      key_valid  <= 1'b0;
      busy       <= 1'b0;
      finish     <= 1'b0;
`ifdef PRIME_KEY_SIEVE_EN
      sieve_start <= 1'b0;
`endif
    end else begin
      test_start <= 1'b0;
`ifdef PRIME_KEY_SIEVE_EN
      sieve_start <= 1'b0;
`endif
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state     <= ST_FILL;
            word_cnt  <= '0;
            key_cnt   <= '0;
            tries     <= '0;
            step_cnt  <= '0;
            rnd_ready <= 1'b1;
            busy      <= 1'b1;
            finish    <= 1'b0;
          end
        end
        ST_FILL: begin
          if (rnd_valid) begin
            if (word_cnt == LAST_WORD) begin
              cand      <= cand_fill | MSB_ONE | LSB_ONE;
              rnd_ready <= 1'b0;
`ifdef PRIME_KEY_SIEVE_EN
              state       <= ST_SIEVE;
              sieve_start <= 1'b1;
`else
              state      <= ST_TEST;
              test_start <= 1'b1;
`endif
            end else begin
              cand     <= cand_fill;
              word_cnt <= word_cnt + 1'b1;
            end
          end
        end
`ifdef PRIME_KEY_SIEVE_EN
        ST_SIEVE: begin
          if (sieve_done) begin
            if (!sieve_composite) begin
              state      <= ST_TEST;
              test_start <= 1'b1;
            end else if (step_cnt == LAST_STEP) begin
              step_cnt  <= '0;
              word_cnt  <= '0;
              state     <= ST_FILL;
              rnd_ready <= 1'b1;
            end else begin
              step_cnt    <= step_cnt + 1'b1;
              cand        <= cand_step;
              sieve_start <= 1'b1;
            end
          end
        end
`endif
        ST_TEST: begin
          tries <= (tries == '1) ? tries : tries + 1'b1;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (test_done) begin
            if (test_prime) begin
              state     <= ST_EMIT;
              key_valid <= 1'b1;
            end else if (step_cnt == LAST_STEP) begin
              step_cnt  <= '0;
              word_cnt  <= '0;
              state     <= ST_FILL;
              rnd_ready <= 1'b1;
            end else begin
              step_cnt <= step_cnt + 1'b1;
              cand     <= cand_step;
`ifdef PRIME_KEY_SIEVE_EN
              state       <= ST_SIEVE;
              sieve_start <= 1'b1;
`else
              state      <= ST_TEST;
              test_start <= 1'b1;
`endif
            end
          end
        end
        ST_EMIT: begin
          if (key_ready) begin
            key_valid <= 1'b0;
            tries     <= '0;
            step_cnt  <= '0;
            word_cnt  <= '0;
            if (key_cnt == LAST_KEY) begin
              state  <= ST_DONE;
              busy   <= 1'b0;
              finish <= 1'b1;
            end else begin
              key_cnt   <= key_cnt + 1'b1;
              state     <= ST_FILL;
              rnd_ready <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign key_out = cand;
  assign key_idx = key_cnt;

endmodule

// File: tb/tb_prime_key_seq.sv
// Bench for prime_key_seq: a behavioural model of the key-generation rules
// tracks every cycle on a 32-bit, 2-key, 4-step instance; a 16-bit instance
// covers the +2 wrap case with direct literal checks.
module tb_prime_key_seq;

  localparam int W  = 32;
  localparam int NK = 2;
  localparam int MS = 4;
  localparam int NW = W / 16;
  localparam logic [W-1:0] MSBV = {1'b1, {(W-1){1'b0}}};

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // main instance
  logic          start = 0, rnd_valid = 0, test_done = 0, test_prime = 0, key_ready = 0;
  logic [15:0]   rnd_word = 0;
  logic          rnd_ready, test_start, key_valid, busy, finish;
  logic [W-1:0]  cand, key_out;
  logic [7:0]    key_idx;
  logic [15:0]   tries;

  // 16-bit instance
  logic          s_start = 0, s_valid = 0, s_done = 0, s_prime = 0, s_kready = 0;
  logic [15:0]   s_word = 0;
  logic          s_rnd_ready, s_test_start, s_key_valid, s_busy, s_finish;
  logic [15:0]   s_cand, s_key_out, s_tries;
  logic [7:0]    s_key_idx;

  prime_key_seq #(.WORDSIZE(W), .NUM_KEYS(NK), .MAX_STEPS(MS)) dut (
    .clk(clk), .reset(reset), .start(start), .rnd_word(rnd_word), .rnd_valid(rnd_valid),
    .rnd_ready(rnd_ready), .cand(cand), .test_start(test_start), .test_done(test_done),
    .test_prime(test_prime), .key_out(key_out), .key_idx(key_idx), .tries(tries),
    .key_valid(key_valid), .key_ready(key_ready), .busy(busy), .finish(finish)
  );

  prime_key_seq #(.WORDSIZE(16), .NUM_KEYS(1), .MAX_STEPS(4)) dut16 (
    .clk(clk), .reset(reset), .start(s_start), .rnd_word(s_word), .rnd_valid(s_valid),
    .rnd_ready(s_rnd_ready), .cand(s_cand), .test_start(s_test_start), .test_done(s_done),
    .test_prime(s_prime), .key_out(s_key_out), .key_idx(s_key_idx), .tries(s_tries),
    .key_valid(s_key_valid), .key_ready(s_kready), .busy(s_busy), .finish(s_finish)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // environment state: stimulus queues and tester emulation
  bit          env_en = 0;
  logic [15:0] word_q[$];
  bit          resp_q[$];
  bit          start_req = 0, kr = 0, spur_req = 0;
  int          tdelay = 0;
  bit          tresp = 0, tdone_now = 0;
  int          cyc = 0;

  // model of what the block must be doing
  bit          m_fill, m_test_due, m_emit, m_busy, m_done;
  int          m_wcnt, m_tries, m_steps, m_kidx;
  logic [W-1:0] m_asm, m_cand;

  task automatic model_reset();
    m_fill = 0; m_test_due = 0; m_emit = 0; m_busy = 0; m_done = 0;
    m_wcnt = 0; m_tries = 0; m_steps = 0; m_kidx = 0;
    m_asm = '0; m_cand = '0;
    tdelay = 0; word_q.delete(); resp_q.delete();
  endtask

  // Per-cycle compare, input drive and model update (all at negedge).
  initial begin : env
    model_reset();
    forever begin
      @(negedge clk);
      cyc++;
      if (!env_en || reset) begin
        start = 0; rnd_valid = 0; rnd_word = 0; test_done = 0; test_prime = 0; key_ready = 0;
      end else begin
        chk("test_start", test_start, m_test_due);
        chk("rnd_ready", rnd_ready, m_fill);
        chk("key_valid", key_valid, m_emit);
        chk("busy", busy, m_busy);
        chk("finish", finish, m_done);
        chk("tries", tries, m_tries);
        if (m_busy && !m_fill) chk("cand", cand, m_cand);
        if (key_valid) begin
          chk("key_out", key_out, m_cand);
          chk("key_idx", key_idx, m_kidx);
        end

        start = start_req;
        start_req = 0;
        rnd_valid = (word_q.size() > 0) && (cyc % 3 != 2);
        rnd_word = rnd_valid ? word_q[0] : 16'h5A5A;
        key_ready = kr;
        test_done = 0;
        test_prime = 1'($urandom_range(0, 1));
        tdone_now = 0;
        if (tdelay > 0) begin
          tdelay--;
          if (tdelay == 0) begin
            test_done = 1; test_prime = tresp; tdone_now = 1;
          end
        end else if (spur_req && m_fill) begin
          test_done = 1; test_prime = 1; spur_req = 0;
        end

        m_test_due = 0;
        if (test_start) begin
          if (m_tries < 65535) m_tries++;
          tdelay = 2;
          tresp = (resp_q.size() > 0) ? resp_q.pop_front() : 1'b1;
        end
        if (m_fill && rnd_valid) begin
          void'(word_q.pop_front());
          m_asm[m_wcnt*16 +: 16] = rnd_word;
          m_wcnt++;
          if (m_wcnt == NW) begin
            m_cand = m_asm | MSBV | W'(1);
            m_fill = 0;
            m_test_due = 1;
          end
        end
        if (m_emit && key_ready) begin
          m_emit = 0; m_tries = 0; m_steps = 0;
          if (m_kidx == NK - 1) begin
            m_busy = 0; m_done = 1;
          end else begin
            m_kidx++; m_fill = 1; m_wcnt = 0;
          end
        end
        if (tdone_now) begin
          if (tresp) m_emit = 1;
          else if (m_steps == MS - 1) begin
            m_steps = 0; m_fill = 1; m_wcnt = 0;
          end else begin
            m_steps++;
            m_cand = (m_cand + W'(2)) | MSBV;
            m_test_due = 1;
          end
        end
        if (start && !m_busy) begin
          m_busy = 1; m_done = 0; m_fill = 1; m_wcnt = 0;
          m_kidx = 0; m_tries = 0; m_steps = 0;
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_test(input string name);
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (test_start) begin ok = 1; break; end
    end
    chk(name, ok, 1);
  endtask

  task automatic wait_key(input string name);
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (key_valid) begin ok = 1; break; end
    end
    chk(name, ok, 1);
  endtask

  initial begin : scenario
    // reset state
    @(posedge clk); #1;
    chk("rst_cand", cand, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rnd_ready", rnd_ready, 0);
    chk("rst_key_valid", key_valid, 0);
    @(posedge clk); #1;
    reset = 0;
    env_en = 1;
    wait_cyc(4);

    // reset in the middle of FILL
    word_q.push_back(16'hABCD);
    start_req = 1;
    wait_cyc(6);
    chk("midfill_rnd_ready", rnd_ready, 1);
    env_en = 0;
    #2 reset = 1;
    #1;
    chk("arst_rnd_ready", rnd_ready, 0);
    chk("arst_busy", busy, 0);
    chk("arst_cand", cand, 0);
    chk("arst_test_start", test_start, 0);
    chk("arst_key_valid", key_valid, 0);
    chk("arst_key_out", key_out, 0);
    chk("arst_tries", tries, 0);
    chk("arst_finish", finish, 0);
    model_reset();
    @(posedge clk); #1;
    reset = 0;
    env_en = 1;
    wait_cyc(5);

    // key 0: fill/force, two composites then prime, held under backpressure
    word_q.push_back(16'h1234);
    word_q.push_back(16'h0000);
    resp_q.push_back(0); resp_q.push_back(0); resp_q.push_back(1);
    kr = 0;
    start_req = 1;
    wait_test("wait_first_test");
    chk("fill_cand", cand, 32'h80001235);
    wait_key("wait_key0");
    chk("k0_out", key_out, 32'h80001239);
    chk("k0_tries", tries, 3);
    chk("k0_idx", key_idx, 0);
    wait_cyc(5);
    chk("k0_hold_out", key_out, 32'h80001239);
    chk("k0_hold_valid", key_valid, 1);

    // key 1: four composites force a redraw; stray test_done during FILL
    word_q.push_back(16'h0010); word_q.push_back(16'h0000);
    word_q.push_back(16'h0020); word_q.push_back(16'h0000);
    for (int i = 0; i < 4; i++) resp_q.push_back(0);
    resp_q.push_back(1);
    spur_req = 1;
    kr = 1;
    wait_key("wait_key1");
    chk("k1_out", key_out, 32'h80000021);
    chk("k1_tries", tries, 5);
    chk("k1_idx", key_idx, 1);
    wait_cyc(1);
    chk("finish_after_last", finish, 1);
    wait_cyc(3);
    start_req = 1;
    wait_cyc(1);
    chk("restart_finish", finish, 0);
    chk("restart_rnd_ready", rnd_ready, 1);
    wait_cyc(3);

    // 16-bit instance: 0xFFFE -> 0xFFFF, composite wraps to 0x8001
    s_word = 16'hFFFE;
    s_start = 1;
    wait_cyc(1);
    s_start = 0;
    s_valid = 1;
    wait_cyc(1);
    s_valid = 0;
    chk("w16_ts0", s_test_start, 1);
    chk("w16_cand0", s_cand, 16'hFFFF);
    wait_cyc(2);
    s_done = 1; s_prime = 0;
    wait_cyc(1);
    s_done = 0;
    chk("w16_ts1", s_test_start, 1);
    chk("w16_cand1", s_cand, 16'h8001);
    wait_cyc(1);
    s_done = 1; s_prime = 1;
    wait_cyc(1);
    s_done = 0;
    chk("w16_valid", s_key_valid, 1);
    chk("w16_key", s_key_out, 16'h8001);
    chk("w16_tries", s_tries, 2);
    s_kready = 1;
    wait_cyc(1);
    chk("w16_finish", s_finish, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1);
  end

endmodule

// File: doc/prime_key_seq.md
Name: prime_key_seq

Overview:
- Parametrised successor to the fixed three-prime key generator: produces NUM_KEYS primes of WORDSIZE bits each, sequentially, from one 16-bit random-word stream.
- Shares a single external primality tester (Miller-Rabin core) through a start/done handshake.
- On a composite result, retries with an incremental +2 search, then redraws a fresh candidate.
- Delivers each key over a valid/ready interface to the key store.

Parameters:
- WORDSIZE, 272, candidate/key width in bits; multiple of 16, at least 16.
- NUM_KEYS, 3, number of primes generated per start.
- MAX_STEPS, 64, primality tests per drawn candidate before a fresh redraw; at least 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin a key set; sampled only in IDLE or DONE.
- rnd_word  in  16  random word from the rand127 instance.
- rnd_valid  in  1  rnd_word is valid.
- rnd_ready  out  1  block consumes rnd_word this cycle.
- cand  out  WORDSIZE  candidate presented to the primality tester.
- test_start  out  1  one-cycle pulse that starts a test of cand.
- test_done  in  1  tester result is valid.
- test_prime  in  1  1 = probably prime; qualified by test_done.
- key_out  out  WORDSIZE  accepted prime.
- key_idx  out  8  index of key_out, 0..NUM_KEYS-1.
- tries  out  16  primality tests spent on the current key; saturating.
- key_valid  out  1  key_out, key_idx and tries are valid.
- key_ready  in  1  consumer accepts the key.
- busy  out  1  state is neither IDLE nor DONE.
- finish  out  1  all NUM_KEYS keys delivered; held high in DONE.

Behaviour:
- Reset (async): state IDLE; every output and internal register cleared to 0.
- Reset mid-operation: abort immediately; no partial key is emitted.
- FSM states: IDLE, FILL, TEST, WAIT, EMIT, DONE (plus SIEVE when the optional feature is compiled in).
- IDLE: on start, go to FILL; word_cnt = 0, key_cnt = 0, tries = 0, step_cnt = 0.
- FILL:
  - rnd_ready = 1.
  - Each cycle with rnd_valid, write rnd_word to cand[(word_cnt+1)*16-1 -: 16]; word 0 is the least-significant word.
  - rnd_valid low stalls FILL.
  - The cycle the last word (WORDSIZE/16 - 1) is written, force cand[0] = 1 and cand[WORDSIZE-1] = 1, then go to TEST.
  - Latency is WORDSIZE/16 accepted words.
- TEST: test_start = 1 for exactly one cycle; tries increments, saturating at 0xFFFF; go to WAIT.
- cand is held stable from TEST until test_done is accepted.
- WAIT: wait for test_done. A test_done seen in any other state is ignored.
  - test_prime = 1: go to EMIT.
  - test_prime = 0 and step_cnt = MAX_STEPS-1: step_cnt = 0, word_cnt = 0, go to FILL.
  - test_prime = 0 otherwise: step_cnt++, cand = cand + 2 mod 2^WORDSIZE, re-force MSB (an all-ones candidate wraps to 10..01), go to TEST.
- EMIT:
  - key_valid = 1; key_out = cand; key_idx = key_cnt.
  - Outputs are held stable until key_valid && key_ready.
  - On the handshake: tries = 0, step_cnt = 0, word_cnt = 0.
  - If key_cnt = NUM_KEYS-1, go to DONE; otherwise key_cnt++ and go to FILL.
- DONE: finish = 1. start restarts exactly as from IDLE (finish drops the same cycle).
- start while busy is ignored.

Optional Feature:
- Macro: PRIME_KEY_SIEVE_EN.
- Enabled: after FILL, and after each +2 step, enter SIEVE before TEST.
  - 2^16 ≡ 1 mod 3, 5 and 17, so cand mod m equals (sum of the 16-bit words) mod m.
  - Accumulate one word per cycle into a 32-bit sum (WORDSIZE/16 cycles).
  - If the sum is divisible by 3, 5 or 17, treat the candidate as composite: count the step, take the same +2 / redraw path, issue no test_start, and leave tries unchanged.
  - Otherwise go to TEST.
- Disabled: SIEVE state and its logic are absent; every candidate goes straight to TEST.

Decomposition:
- Package key_gen_pkg holds:
  - the state encoding;
  - RND_W = 16;
  - the sieve moduli 3, 5, 17;
  - the tries width of 16.
- Sub-module cand_sieve: word-serial mod-3/5/17 accumulator with start/done; instantiated only under PRIME_KEY_SIEVE_EN.

Test Plan:
- Reset: assert reset mid-FILL → all outputs 0 asynchronously; busy=0; after release, no test_start without start.
- Fill and force (WORDSIZE=32): start, words 0x1234 then 0x0000 → cand=0x80001235; single test_start pulse 1 cycle after the second word.
- Incremental retry: tester returns composite, composite, prime → cand sequence 0x80001235, 0x80001237, 0x80001239; key_out=0x80001239, tries=3.
- Redraw on exhaustion (MAX_STEPS=4, always composite): after 4th composite → rnd_ready=1, new words loaded, step_cnt=0, tries=4 continuing to 5.
- Wrap (WORDSIZE=16): word 0xFFFE → cand 0xFFFF; composite → cand 0x8001.
- Backpressure/finish (NUM_KEYS=2): hold key_ready low 5 cycles → key_out/key_idx stable; key_idx 0 then 1; finish=1 the cycle after the second handshake; start in DONE → finish=0, FILL.
